// File: rtl/sram_uart_rx.sv
// sram_uart_rx -- memory-mapped 8N1 UART receiver slave on the SRAM-style data bus.
//
// Samples an asynchronous serial line and rebuilds bytes, LSB first. Completed
// bytes go into a receive FIFO. The load/store port reads them from there,
// together with a status doubleword.
//
// Ports:
//   clka   in   1            clock
//   rst    in   1            synchronous active-high reset
//   addra  in   LEN_ADDR     bus address; only addra[3] is decoded (0 = DATA, 1 = STATUS)
//   dina   in   LEN_DATA     write data (STATUS W1C bits [2] overrun, [3] frame_err)
//   douta  out  LEN_DATA     registered read data, held until the next read
//   ena    in   1            access strobe
//   wea    in   LEN_DATA/8   byte write enables; all zero means read
//   rxd    in   1            asynchronous serial input, idles high
//
// Read DATA  : non-empty -> {.., 1'b1, head byte} and pop; empty -> 0.
// Read STATUS: [0] non-empty, [1] full, [2] overrun, [3] frame_err, [15:8] count.
//
// Receive FSM state is held in `state` (type rx_state_t) so that it can be observed
// hierarchically.
module sram_uart_rx #(
    parameter int LEN_ADDR     = 64,
    parameter int LEN_DATA     = 64,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic [LEN_ADDR-1:0]   addra,
    input  logic [LEN_DATA-1:0]   dina,
    output logic [LEN_DATA-1:0]   douta,
    input  logic                  ena,
    input  logic [LEN_DATA/8-1:0] wea,
    input  logic                  rxd
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = AW + 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } rx_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser. The flops reset to the idle level, so that the
    // release of reset cannot look like a start bit.
    // ------------------------------------------------------------------
    logic [1:0] sync;
    logic       rxd_s;

    always_ff @(posedge clka) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rxd};
        end
    end

    assign rxd_s = sync[1];

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          push;
    logic          frame_set;

    always_ff @(posedge clka) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bit_n     = bit_idx;
        shift_n   = shift;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rxd_s) state_n = S_START;
            end
            S_START: begin
                // Re-check the line in the middle of the start bit. This rejects
                // short glitches. It also places every later sample at mid-bit.
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == FULL_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rxd_s, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (cnt == FULL_LAST) begin
                    cnt_n = '0;
                    if (rxd_s) begin
                        push    = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_n   = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A low line here is a break or a framing fault. It is not a new start bit.
                cnt_n = '0;
                if (rxd_s) state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic rd, rd_data, pop, clr_overrun, clr_frame;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count;
    logic          empty, full, do_push;
    logic          overrun, frame_err;
    logic [7:0]    mem [FIFO_DEPTH];

    assign empty       = (count == '0);
    assign full        = (count == DEPTH_N);
    assign rd          = ena && (wea == '0);
    assign rd_data     = rd && !addra[3];
    assign pop         = rd_data && !empty;
    assign clr_overrun = ena && addra[3] && wea[0] && dina[2];
    assign clr_frame   = ena && addra[3] && wea[0] && dina[3];

    // A full FIFO still accepts a byte when the same cycle pops one.
    assign do_push = push && (!full || pop);

    logic unused_bits;
    assign unused_bits = ^{addra[LEN_ADDR-1:4], addra[2:0], dina[LEN_DATA-1:4], dina[1:0]};

    always_ff @(posedge clka) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

    // ------------------------------------------------------------------
    // Read data. For FIFO_DEPTH = 256 the count needs 9 bits. Only the low
    // 8 bits fit the count field. A count of 256 therefore shows as 0, and
    // the full flag shows that case.
    // ------------------------------------------------------------------
    logic [LEN_DATA-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        if (addra[3]) begin
            rd_word[0]    = !empty;
            rd_word[1]    = full;
            rd_word[2]    = overrun;
            rd_word[3]    = frame_err;
            rd_word[15:8] = 8'(count);
        end else if (!empty) begin
            rd_word[8]   = 1'b1;
            rd_word[7:0] = mem[rd_ptr];
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            douta     <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // When a flag is set and cleared in the same cycle, the set wins.
            if (push && full && !pop) overrun <= 1'b1;
            else if (clr_overrun)     overrun <= 1'b0;
            if (frame_set)            frame_err <= 1'b1;
            else if (clr_frame)       frame_err <= 1'b0;
            if (rd) douta <= rd_word;
        end
    end

endmodule

// File: tb/tb_sram_uart_rx.sv
// Bench for sram_uart_rx: CLKS_PER_BIT = 16, FIFO_DEPTH = 4.
// The expected values come from a transaction-level model. It holds a byte
// queue and two sticky flags, and it is updated once per frame sent and per
// bus access.
module tb_sram_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] addra;
    logic [63:0] dina;
    logic [63:0] douta;
    logic        ena;
    logic [7:0]  wea;
    logic        rxd;

    sram_uart_rx #(
        .LEN_ADDR    (64),
        .LEN_DATA    (64),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clka (clk),
        .rst  (rst),
        .addra(addra),
        .dina (dina),
        .douta(douta),
        .ena  (ena),
        .wea  (wea),
        .rxd  (rxd)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [7:0]  m_q[$];
    logic        m_ov;
    logic        m_fe;
    logic [63:0] m_last;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_status();
        logic [63:0] e;
        e       = '0;
        e[0]    = (m_q.size() > 0);
        e[1]    = (m_q.size() == DEPTH);
        e[2]    = m_ov;
        e[3]    = m_fe;
        e[15:8] = 8'(m_q.size());
        return e;
    endfunction

    function automatic logic [63:0] model_pop();
        logic [63:0] e;
        e = '0;
        if (m_q.size() > 0) begin
            e[8]   = 1'b1;
            e[7:0] = m_q.pop_front();
        end
        return e;
    endfunction

    // One-cycle bus access, driven and sampled on falling edges.
    task automatic bus_access(input logic a3, input logic [7:0] we, input logic [63:0] d);
        ena   = 1'b1;
        addra = a3 ? 64'h8 : 64'h0;
        wea   = we;
        dina  = d;
        @(negedge clk);
        ena  = 1'b0;
        wea  = '0;
        dina = '0;
    endtask

    task automatic read_data_chk(input string tag);
        m_last = model_pop();
        bus_access(1'b0, 8'h00, 64'h0);
        check(tag, douta, m_last);
    endtask

    task automatic read_status_chk(input string tag);
        m_last = model_status();
        bus_access(1'b1, 8'h00, 64'h0);
        check(tag, douta, m_last);
    endtask

    task automatic write_chk(input string tag, input logic a3, input logic [7:0] we,
                             input logic [63:0] d);
        bus_access(a3, we, d);
        if (a3 && we[0]) begin
            if (d[2]) m_ov = 1'b0;
            if (d[3]) m_fe = 1'b0;
        end
        check(tag, douta, m_last);
    endtask

    // Sends one 8N1 frame, starting on a falling edge. When pop_at_stop is set,
    // a DATA read is placed on the clock edge at which the receiver samples the
    // stop bit. rxd falls at n0, the line is synchronised by e2, START is entered
    // at e3, the first data sample is at e27 and the stop sample is at e155.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit pop_at_stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            rxd = frame[c / CPB];
            if (pop_at_stop && c == 10 * CPB - 6) begin
                ena   = 1'b1;
                addra = 64'h0;
                wea   = '0;
            end
            if (pop_at_stop && c == 10 * CPB - 5) begin
                ena    = 1'b0;
                m_last = model_pop();
                check("pop_at_stop", douta, m_last);
            end
            @(negedge clk);
        end
        if (stop) begin
            if (m_q.size() == DEPTH) m_ov = 1'b1;
            else                     m_q.push_back(b);
        end else begin
            m_fe = 1'b1;
        end
    endtask

    initial begin
        int n;
        logic [7:0] rb;

        rst   = 1'b1;
        rxd   = 1'b1;
        ena   = 1'b0;
        addra = '0;
        dina  = '0;
        wea   = '0;
        m_ov  = 1'b0;
        m_fe  = 1'b0;
        m_last = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_douta", douta, 64'h0);
        read_status_chk("reset_status");

        // Single frame
        send_frame(8'hA5, 1'b1, 1'b0);
        read_data_chk("data_a5");
        read_status_chk("status_after_a5");

        // Back-to-back frames
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        // A read set up with ena low must have no effect.
        addra = 64'h0;
        wea   = '0;
        repeat (2) @(negedge clk);
        check("ena_low_hold", douta, m_last);
        read_status_chk("status_three");
        read_data_chk("data_11");
        write_chk("write_data_ignored", 1'b0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        read_data_chk("data_22");
        read_data_chk("data_33");
        read_data_chk("data_empty");

        // Short glitch is rejected.
        rxd = 1'b0;
        repeat (6) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        read_status_chk("status_glitch");

        // Overrun
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        read_status_chk("status_overrun");
        for (int i = 0; i < 4; i++) read_data_chk("data_overrun_drain");
        write_chk("clear_overrun", 1'b1, 8'h01, 64'h4);
        read_status_chk("status_cleared");

        // Framing error followed by a held-low line
        send_frame(8'h7E, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        read_status_chk("status_frame_err");
        send_frame(8'h42, 1'b1, 1'b0);
        read_data_chk("data_42");
        write_chk("clear_frame_err", 1'b1, 8'h01, 64'h8);
        read_status_chk("status_fe_cleared");

        // A full FIFO with the pop in the same cycle as the stop sample
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        send_frame(8'h99, 1'b1, 1'b1);
        read_status_chk("status_full_pop");
        for (int i = 0; i < DEPTH; i++) read_data_chk("data_full_pop_drain");

        // Randomised bursts, which sometimes overrun
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                rb = 8'($urandom_range(0, 255));
                send_frame(rb, 1'b1, 1'b0);
            end
            read_status_chk("rand_status");
            for (int i = 0; i <= n; i++) read_data_chk("rand_data");
            write_chk("rand_clear", 1'b1, 8'h01, 64'hC);
            read_status_chk("rand_status_clear");
        end

        // Reset in the middle of a frame, with one byte already queued
        send_frame(8'h5A, 1'b1, 1'b0);
        read_status_chk("status_before_rst");
        rb = 8'hC3;
        for (int c = 0; c < 70; c++) begin
            rxd = (c < CPB) ? 1'b0 : rb[(c - CPB) / CPB];
            @(negedge clk);
        end
        rst = 1'b1;
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_q.delete();
        m_ov   = 1'b0;
        m_fe   = 1'b0;
        m_last = '0;
        check("rst_mid_douta", douta, 64'h0);
        read_status_chk("rst_mid_status");
        repeat (4) @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b0);
        read_data_chk("data_after_rst");
        read_status_chk("status_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
